// File: rtl/s2qed_pkg.sv
// S2QED output checker shared definitions: vector layout, FSM states,
// and the per-instance output packing helper.
package s2qed_pkg;

  localparam int VEC_W      = 18;
  localparam int RTS_B      = 17;
  localparam int TXD_B      = 16;
  localparam int KEYYO_LSB  = 11;
  localparam int KEYYO_W    = 5;
  localparam int LCDDBO_LSB = 3;
  localparam int LCDDBO_W   = 8;
  localparam int LCDE_B     = 2;
  localparam int LCDRW_B    = 1;
  localparam int LCDRS_B    = 0;

  // ARMED is also a port name on the top, hence the prefix.
  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FAILED = 2'd2
  } state_e;

  function automatic logic [VEC_W-1:0] pack_vec(
    input logic                rts,
    input logic                txd,
    input logic [KEYYO_W-1:0]  keyyo,
    input logic [LCDDBO_W-1:0] lcddbo,
    input logic                lcde,
    input logic                lcdrw,
    input logic                lcdrs
  );
    logic [VEC_W-1:0] v;
    v                            = '0;
    v[RTS_B]                     = rts;
    v[TXD_B]                     = txd;
    v[KEYYO_LSB +: KEYYO_W]      = keyyo;
    v[LCDDBO_LSB +: LCDDBO_W]    = lcddbo;
    v[LCDE_B]                    = lcde;
    v[LCDRW_B]                   = lcdrw;
    v[LCDRS_B]                   = lcdrs;
    return v;
  endfunction

endpackage

// File: rtl/s2qed_sat_counter.sv
// Saturating up-counter: counts while en_i is high, holds at all-ones.
module s2qed_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/s2qed_output_checker.sv
// Cycle-by-cycle comparator of the two S2QED SoC instances with sticky
// first-failure capture. Optional persistence filter: S2QED_SKEW_TOL_EN.
module s2qed_output_checker
  import s2qed_pkg::*;
#(
  parameter int WARMUP_CYCLES = 16,
  parameter int CYC_W         = 32,
  parameter int CNT_W         = 16,
  parameter int SKEW_TOL      = 1
) (
  input  logic             CLK_SRC,
  input  logic             RST,
  input  logic             CHK_EN,
  input  logic             LCDRS_0,
  input  logic             LCDRW_0,
  input  logic             LCDE_0,
  input  logic [7:0]       LCDDBO_0,
  input  logic [4:0]       KEYYO_0,
  input  logic             TXD_0,
  input  logic             RTS_0,
  input  logic             LCDRS_1,
  input  logic             LCDRW_1,
  input  logic             LCDE_1,
  input  logic [7:0]       LCDDBO_1,
  input  logic [4:0]       KEYYO_1,
  input  logic             TXD_1,
  input  logic             RTS_1,
  output logic             ARMED,
  output logic             MISMATCH,
  output logic             MISMATCH_PULSE,
  output logic [VEC_W-1:0] FIRST_VEC,
  output logic [CYC_W-1:0] FIRST_CYC,
  output logic [CNT_W-1:0] MISMATCH_CNT
);

  if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_bad_warmup
    $error("WARMUP_CYCLES out of range 1..255");
  end
  if (SKEW_TOL < 1 || SKEW_TOL > 7) begin : g_bad_skew
    $error("SKEW_TOL out of range 1..7");
  end

  localparam logic [7:0] WLAST = 8'(WARMUP_CYCLES - 1);

  logic [VEC_W-1:0] v0_q, v1_q;
  logic [VEC_W-1:0] diff;
  logic             raw_mm;
  logic             hit;
  logic             live;
  logic             cnt_hit;
  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [VEC_W-1:0] first_vec_q, first_vec_d;
  logic [CYC_W-1:0] first_cyc_q, first_cyc_d;
  logic [CYC_W-1:0] cyc;
  logic             armed_q, mismatch_q, pulse_q;

  always_ff @(posedge CLK_SRC or posedge RST) begin
    if (RST) begin
      v0_q <= '0;
      v1_q <= '0;
    end else begin
      v0_q <= pack_vec(RTS_0, TXD_0, KEYYO_0, LCDDBO_0,
                       LCDE_0, LCDRW_0, LCDRS_0);
      v1_q <= pack_vec(RTS_1, TXD_1, KEYYO_1, LCDDBO_1,
                       LCDE_1, LCDRW_1, LCDRS_1);
    end
  end

  // Data bus is only meaningful while either side strobes LCDE.
  always_comb begin
    diff = v0_q ^ v1_q;
    if (!(v0_q[LCDE_B] || v1_q[LCDE_B])) begin
      diff[LCDDBO_LSB +: LCDDBO_W] = '0;
    end
  end

  assign raw_mm = |diff;

`ifdef S2QED_SKEW_TOL_EN
  localparam logic [2:0] TOL = 3'(SKEW_TOL);

  logic [2:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = '0;
    if (CHK_EN && raw_mm) begin
      pcnt_d = (pcnt_q == TOL) ? pcnt_q : pcnt_q + 3'd1;
    end
  end

  always_ff @(posedge CLK_SRC or posedge RST) begin
    if (RST) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign hit = CHK_EN && raw_mm && (pcnt_q == TOL);
`else
  assign hit = CHK_EN && raw_mm;
`endif

  assign live    = (state_q != ST_WARMUP);
  assign cnt_hit = live && hit;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    first_vec_d = first_vec_q;
    first_cyc_d = first_cyc_q;
    unique case (state_q)
      ST_WARMUP: begin
        wcnt_d = wcnt_q + 8'd1;
        if (wcnt_q == WLAST) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (hit) begin
          state_d     = ST_FAILED;
          first_vec_d = diff;
          first_cyc_d = cyc;
        end
      end
      ST_FAILED: begin
        state_d = ST_FAILED;
      end
      default: begin
        state_d = ST_WARMUP;
      end
    endcase
  end

  always_ff @(posedge CLK_SRC or posedge RST) begin
    if (RST) begin
      state_q     <= ST_WARMUP;
      wcnt_q      <= '0;
      first_vec_q <= '0;
      first_cyc_q <= '0;
      armed_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      first_vec_q <= first_vec_d;
      first_cyc_q <= first_cyc_d;
      armed_q     <= (state_d != ST_WARMUP);
      mismatch_q  <= (state_d == ST_FAILED);
      pulse_q     <= cnt_hit;
    end
  end

  s2qed_sat_counter #(.W(CYC_W)) u_cyc (
    .clk_i (CLK_SRC),
    .rst_i (RST),
    .en_i  (live),
    .cnt_o (cyc)
  );

  s2qed_sat_counter #(.W(CNT_W)) u_mm_cnt (
    .clk_i (CLK_SRC),
    .rst_i (RST),
    .en_i  (cnt_hit),
    .cnt_o (MISMATCH_CNT)
  );

  assign ARMED          = armed_q;
  assign MISMATCH       = mismatch_q;
  assign MISMATCH_PULSE = pulse_q;
  assign FIRST_VEC      = first_vec_q;
  assign FIRST_CYC      = first_cyc_q;

endmodule

// File: tb/tb_s2qed_output_checker.sv
// Directed self-checking bench for s2qed_output_checker (CNT_W=4).
module tb_s2qed_output_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        chk_en;
  logic [17:0] v0, v1;

  logic        armed, mm, pulse;
  logic [17:0] fvec;
  logic [31:0] fcyc;
  logic [3:0]  mcnt;

  int checks = 0;
  int errors = 0;
  int cyc_m  = 0;

  always #5 clk = ~clk;

  s2qed_output_checker #(
    .WARMUP_CYCLES (16),
    .CYC_W         (32),
    .CNT_W         (4),
    .SKEW_TOL      (1)
  ) dut (
    .CLK_SRC        (clk),
    .RST            (rst),
    .CHK_EN         (chk_en),
    .LCDRS_0        (v0[0]),
    .LCDRW_0        (v0[1]),
    .LCDE_0         (v0[2]),
    .LCDDBO_0       (v0[10:3]),
    .KEYYO_0        (v0[15:11]),
    .TXD_0          (v0[16]),
    .RTS_0          (v0[17]),
    .LCDRS_1        (v1[0]),
    .LCDRW_1        (v1[1]),
    .LCDE_1         (v1[2]),
    .LCDDBO_1       (v1[10:3]),
    .KEYYO_1        (v1[15:11]),
    .TXD_1          (v1[16]),
    .RTS_1          (v1[17]),
    .ARMED          (armed),
    .MISMATCH       (mm),
    .MISMATCH_PULSE (pulse),
    .FIRST_VEC      (fvec),
    .FIRST_CYC      (fcyc),
    .MISMATCH_CNT   (mcnt)
  );

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic        en;
    logic        pls;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_m++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;
    v0     = '0;
    v1     = '0;
    #2;
    rst    = 1'b0;
  endtask

  task automatic arm();
    repeat (16) tick();
    cyc_m = 0;
  endtask

  initial begin
    logic [31:0] r;
    int          exp_cnt;
    logic [31:0] exp_fc;
    bit          seen;

    // LCDDBO A5/5A sit at bits 10:3 -> 18'h528 / 18'h2D0.
    tbl[0] = '{18'h00528, 18'h002D0, 1'b1, 1'b0};
    tbl[1] = '{18'h0052C, 18'h002D0, 1'b1, 1'b1};
    tbl[2] = '{18'h0052C, 18'h002D4, 1'b1, 1'b1};
    tbl[3] = '{18'h20000, 18'h00000, 1'b1, 1'b1};
    tbl[4] = '{18'h0F800, 18'h00000, 1'b1, 1'b1};
    tbl[5] = '{18'h00002, 18'h00000, 1'b1, 1'b1};
    tbl[6] = '{18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0};
    tbl[7] = '{18'h10000, 18'h00000, 1'b0, 1'b0};
    tbl[8] = '{18'h00529, 18'h002D0, 1'b1, 1'b1};

    rst    = 1'b1;
    chk_en = 1'b1;
    v0     = '0;
    v1     = '0;
    #12;
    check("rst_armed", armed, 0);
    check("rst_mm",    mm,    0);
    check("rst_pulse", pulse, 0);
    check("rst_fvec",  fvec,  0);
    check("rst_fcyc",  fcyc,  0);
    check("rst_cnt",   mcnt,  0);
    rst = 1'b0;

`ifndef S2QED_SKEW_TOL_EN
    // Warm-up boundary and clean identical traffic.
    repeat (15) tick();
    check("warm15_armed", armed, 0);
    tick();
    check("warm16_armed", armed, 1);
    cyc_m = 0;
    for (int i = 0; i < 39; i++) begin
      r  = $urandom;
      v0 = r[17:0];
      v1 = r[17:0];
      tick();
      check("ident_pulse", pulse, 0);
    end
    check("ident_mm",    mm,    0);
    check("ident_cnt",   mcnt,  0);
    check("ident_armed", armed, 1);

    // TXD divergence registered in armed cycle 40.
    v0 = 18'h10000;
    v1 = 18'h00000;
    tick();
    check("txd_mm_n1", mm, 0);
    v0 = '0;
    tick();
    check("txd_mm",    mm,    1);
    check("txd_pulse", pulse, 1);
    check("txd_fvec",  fvec,  18'h10000);
    check("txd_fcyc",  fcyc,  40);
    check("txd_cnt",   mcnt,  1);
    tick();
    check("txd_pulse_off", pulse, 0);
    check("txd_cnt_hold",  mcnt,  1);
    check("txd_mm_hold",   mm,    1);

    // Table of single-cycle patterns.
    do_reset();
    arm();
    exp_cnt = 0;
    exp_fc  = '0;
    seen    = 1'b0;
    for (int i = 0; i < 9; i++) begin
      v0     = tbl[i].a;
      v1     = tbl[i].b;
      chk_en = tbl[i].en;
      if (tbl[i].pls && !seen) begin
        seen   = 1'b1;
        exp_fc = 32'(cyc_m + 1);
      end
      tick();
      v0 = '0;
      v1 = '0;
      tick();
      if (tbl[i].pls) exp_cnt++;
      check($sformatf("tbl%0d_pulse", i), pulse, tbl[i].pls);
      check($sformatf("tbl%0d_cnt", i), mcnt, exp_cnt);
    end
    chk_en = 1'b1;
    check("tbl_fvec", fvec, 18'h007FC);
    check("tbl_fcyc", fcyc, exp_fc);
    check("tbl_mm",   mm,   1);

    // KEYYO difference held while disabled, then enabled.
    do_reset();
    arm();
    chk_en = 1'b0;
    v0     = 18'h0F800;
    v1     = 18'h00000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dis_pulse", pulse, 0);
    end
    check("dis_cnt",   mcnt,  0);
    check("dis_mm",    mm,    0);
    check("dis_armed", armed, 1);
    chk_en = 1'b1;
    exp_fc = 32'(cyc_m);
    tick();
    check("en_pulse", pulse, 1);
    check("en_cnt",   mcnt,  1);
    check("en_fvec",  fvec,  18'h0F800);
    check("en_fcyc",  fcyc,  exp_fc);
    repeat (2) tick();
    check("en_cnt3", mcnt, 3);

    // Asynchronous reset in FAILED, difference still present.
    #2;
    rst = 1'b1;
    #1;
    check("arst_armed", armed, 0);
    check("arst_mm",    mm,    0);
    check("arst_pulse", pulse, 0);
    check("arst_fvec",  fvec,  0);
    check("arst_fcyc",  fcyc,  0);
    check("arst_cnt",   mcnt,  0);
    rst = 1'b0;

    // Difference persisting through warm-up into ARMED.
    repeat (15) tick();
    check("pers_warm_armed", armed, 0);
    check("pers_warm_mm",    mm,    0);
    tick();
    check("pers_armed", armed, 1);
    check("pers_mm0",   mm,    0);
    tick();
    check("pers_mm",    mm,    1);
    check("pers_fcyc",  fcyc,  0);
    check("pers_fvec",  fvec,  18'h0F800);
    check("pers_cnt",   mcnt,  1);

    // Continuous difference saturates the 4-bit counter.
    repeat (20) tick();
    check("sat_cnt", mcnt, 15);
    repeat (5) tick();
    check("sat_hold", mcnt, 15);
    check("sat_pulse", pulse, 1);

    // Single-cycle glitch is flagged in strict mode.
    do_reset();
    arm();
    v0 = 18'h10000;
    tick();
    v0 = '0;
    tick();
    check("glitch_mm", mm, 1);
`else
    // Persistence filter with SKEW_TOL=1.
    repeat (15) tick();
    check("warm15_armed", armed, 0);
    tick();
    check("warm16_armed", armed, 1);
    cyc_m = 0;
    v0 = 18'h10000;
    tick();
    v0 = '0;
    repeat (4) tick();
    check("g1_mm",  mm,   0);
    check("g1_cnt", mcnt, 0);
    v0 = 18'h10000;
    tick();
    tick();
    v0 = '0;
    check("g2_mm_n2", mm, 0);
    tick();
    check("g2_mm",   mm,   1);
    check("g2_fvec", fvec, 18'h10000);
    check("g2_cnt",  mcnt, 1);
    tick();
    check("g2_cnt_hold", mcnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
